// File: rtl/z16_instr_loader.sv
// Byte-stream program loader: assembles little-endian byte pairs into 16-bit
// instruction words and writes them to instruction memory, holding the CPU meanwhile.
module z16_instr_loader #(
    parameter int MEM_WORDS = 32768
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_base_addr,
    input  logic [15:0] i_word_count,
    input  logic        i_abort,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_we,
    output logic [15:0] o_waddr,
    output logic [15:0] o_wdata,
    output logic        o_busy,
    output logic        o_cpu_hold,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [16:0] MEM_LIMIT = 17'(MEM_WORDS);

    state_t      state_q;
    logic [15:0] addr_q;
    logic [15:0] remaining_q;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic        err_q;

    logic [16:0] end_word;
    logic        xfer;

    // Word index one past the last word of the request, kept 17 bits so it cannot wrap.
    assign end_word = 17'(i_base_addr >> 1) + {1'b0, i_word_count};
    assign xfer     = i_byte_valid & o_byte_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 16'h0000;
            remaining_q <= 16'h0000;
            lo_q        <= 8'h00;
            hi_q        <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // Abort wins over everything outside IDLE; a write already in WR still goes out.
            if (i_abort && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (i_start) begin
                            if (i_word_count == 16'h0000) begin
                                state_q <= S_DONE;
                            end else if (end_word > MEM_LIMIT) begin
                                err_q <= 1'b1;
                            end else begin
                                addr_q      <= i_base_addr & 16'hFFFE;
                                remaining_q <= i_word_count;
                                state_q     <= S_LO;
                            end
                        end
                    end
                    S_LO: begin
                        if (xfer) begin
                            lo_q    <= i_byte;
                            state_q <= S_HI;
                        end
                    end
                    S_HI: begin
                        if (xfer) begin
                            hi_q    <= i_byte;
                            state_q <= S_WR;
                        end
                    end
                    S_WR: begin
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            state_q <= S_DONE;
                        end else begin
                            addr_q  <= addr_q + 16'd2;
                            state_q <= S_LO;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_byte_ready = (state_q == S_LO) || (state_q == S_HI);
    assign o_we         = (state_q == S_WR);
    assign o_waddr      = addr_q;
    assign o_wdata      = {hi_q, lo_q};
    assign o_busy       = (state_q != S_IDLE);
    assign o_cpu_hold   = o_busy;
    assign o_done       = (state_q == S_DONE);
    assign o_err        = err_q;

endmodule

// File: tb/tb_z16_instr_loader.sv
// Scoreboard bench for z16_instr_loader: a request-level model queues expected
// writes/done/err events; a negedge monitor pops and compares them.
module tb_z16_instr_loader;

    localparam int MEMW = 16;
    localparam int EV_WR = 0, EV_DONE = 1, EV_ERR = 2;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [15:0] i_base_addr = 16'h0;
    logic [15:0] i_word_count = 16'h0;
    logic        i_abort = 1'b0;
    logic [7:0]  i_byte = 8'h0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready, o_we, o_busy, o_cpu_hold, o_done, o_err;
    logic [15:0] o_waddr, o_wdata;

    ev_t      exp_q[$];
    int       total = 0;
    int       bad = 0;
    logic [7:0] bytes_mem [0:63];

    z16_instr_loader #(.MEM_WORDS(MEMW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_word_count(i_word_count), .i_abort(i_abort), .i_byte(i_byte),
        .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready), .o_we(o_we),
        .o_waddr(o_waddr), .o_wdata(o_wdata), .o_busy(o_busy), .o_cpu_hold(o_cpu_hold),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic pop_check(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none (addr=%h data=%h t=%0t)",
                     kind, o_waddr, o_wdata, $time);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == EV_WR && e.kind == EV_WR) begin
                chk("waddr", o_waddr, e.addr);
                chk("wdata", o_wdata, e.data);
                $display("write addr=%h data=%h", o_waddr, o_wdata);
            end
        end
    endtask

    // Monitor: every presented output event must match the head of the queue.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_cpu_hold !== o_busy) chk("hold_eq_busy", o_cpu_hold, o_busy);
            if (o_we)   pop_check(EV_WR);
            if (o_done) pop_check(EV_DONE);
            if (o_err)  pop_check(EV_ERR);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input logic [15:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        i_byte_valid = 1'b0;
        repeat (gap) tick();
        i_byte_valid = 1'b1;
        i_byte = b;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_byte_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("byte_accept_timeout", 0, 1);
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (!o_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic issue_start(input logic [15:0] base, input logic [15:0] cnt);
        i_base_addr = base;
        i_word_count = cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // Full load using bytes_mem; the model derives the expected events from the request alone.
    task automatic run_load(input logic [15:0] base, input int cnt, input int gap_max, input bit poke_start);
        int words_end = int'(base >> 1) + cnt;
        $display("load base=%h count=%0d", base, cnt);
        if (cnt == 0) begin
            push_ev(EV_DONE, 0, 0);
        end else if (words_end > MEMW) begin
            push_ev(EV_ERR, 0, 0);
        end else begin
            for (int w = 0; w < cnt; w++)
                push_ev(EV_WR, (base & 16'hFFFE) + 16'(2 * w), {bytes_mem[2*w+1], bytes_mem[2*w]});
            push_ev(EV_DONE, 0, 0);
        end
        issue_start(base, 16'(cnt));
        if (cnt != 0 && words_end > MEMW) begin
            @(negedge i_clk);
            chk("err_busy_low", o_busy, 0);
            tick();
            return;
        end
        for (int i = 0; i < 2 * cnt; i++) begin
            send_byte(bytes_mem[i], $urandom_range(0, gap_max));
            if (poke_start && i == 0) begin
                i_base_addr = 16'h0000;
                i_word_count = 16'h0001;
                i_start = 1'b1;
                tick();
                i_start = 1'b0;
            end
        end
        wait_idle();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_we", o_we, 0);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ready", o_byte_ready, 0);
        chk("rst_done_err", {o_done, o_err, o_cpu_hold}, 0);
        i_rst = 1'b0;
        tick();

        bytes_mem[0] = 8'h40; bytes_mem[1] = 8'h00;
        run_load(16'h0000, 1, 0, 0);
        bytes_mem[0] = 8'h5D; bytes_mem[1] = 8'h60; bytes_mem[2] = 8'h00; bytes_mem[3] = 8'h00;
        run_load(16'h0002, 2, 0, 0);
        bytes_mem[0] = 8'hA5; bytes_mem[1] = 8'h3C;
        run_load(16'h0003, 1, 2, 0);
        run_load(16'h001E, 2, 0, 0);
        run_load(16'h0010, 0, 0, 0);
        bytes_mem[0] = 8'h11; bytes_mem[1] = 8'h22; bytes_mem[2] = 8'h33; bytes_mem[3] = 8'h44;
        run_load(16'h0008, 2, 5, 1);
        run_load(16'h001C, 2, 0, 0);

        $display("abort after one byte");
        issue_start(16'h0004, 16'd2);
        send_byte(8'h77, 0);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        @(negedge i_clk);
        chk("abort_busy", o_busy, 0);

        $display("abort during write");
        push_ev(EV_WR, 16'h0006, 16'hBEEF);
        issue_start(16'h0006, 16'd1);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        @(negedge i_clk);
        chk("abort_wr_busy", o_busy, 0);

        $display("reset mid-load");
        push_ev(EV_WR, 16'h000A, 16'h2211);
        issue_start(16'h000A, 16'd2);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_we_ready", {o_we, o_byte_ready}, 0);
        chk("midrst_waddr", o_waddr, 0);
        chk("midrst_wdata", o_wdata, 0);
        tick();
        i_rst = 1'b0;
        tick();

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 12; i++) bytes_mem[i] = 8'($urandom);
            run_load(16'($urandom_range(0, 40)), $urandom_range(0, 5), 5, ($urandom_range(0, 3) == 0));
        end

        repeat (4) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
